// File: rtl/fp_cmp_ctrl.sv
// fp_cmp_ctrl: initiator-side sequencer for the floating-point compare unit.
// Accepts FEQ/FLT/FLE requests, drives the comparator until done, returns a
// 1-bit result with flags and tag, and accumulates sticky fflags.
// Optional macro: FP_CMP_CTRL_TIMEOUT_EN adds a watchdog on the done wait.

package fp_cmp_pkg;
  typedef enum logic [1:0] {FP32 = 2'd0, FP64 = 2'd1, FP16 = 2'd2, BF16 = 2'd3} fp_format_e;

  // RISC-V fflags ordering: NV is the most significant bit.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  function automatic int unsigned fp_width(fp_format_e fmt);
    case (fmt)
      FP64:       return 64;
      FP16, BF16: return 16;
      default:    return 32;
    endcase
  endfunction
endpackage

module fp_cmp_ctrl
  import fp_cmp_pkg::*;
#(
  parameter fp_format_e  FP_FORMAT      = FP32,
  parameter int unsigned TAG_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned FP_WIDTH      = fp_width(FP_FORMAT)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [1:0]           req_op_i,
  input  logic [FP_WIDTH-1:0]  req_a_i,
  input  logic [FP_WIDTH-1:0]  req_b_i,
  input  logic [TAG_WIDTH-1:0] req_tag_i,
  output logic [FP_WIDTH-1:0]  cmp_a_o,
  output logic [FP_WIDTH-1:0]  cmp_b_o,
  output logic                 cmp_start_o,
  output logic                 cmp_eq_en_o,
  input  logic                 cmp_lt_i,
  input  logic                 cmp_le_i,
  input  logic                 cmp_eq_i,
  input  logic                 cmp_done_i,
  input  status_t              cmp_flags_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_result_o,
  output status_t              rsp_flags_o,
  output logic [TAG_WIDTH-1:0] rsp_tag_o,
  output status_t              fflags_o,
  input  logic                 fflags_clr_i
);

  localparam logic [1:0] OP_FEQ = 2'd0;
  localparam logic [1:0] OP_FLT = 2'd1;
  localparam logic [1:0] OP_RSV = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic [FP_WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic [1:0]             op_q, op_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic                   result_q, result_d;
  status_t                flags_q, flags_d;
  status_t                fflags_q, fflags_d;
  logic                   load;

`ifdef FP_CMP_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]       cnt_q, cnt_d;
`endif

  // Next-state, operand capture, result capture and sticky-flag update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    tag_d    = tag_q;
    result_d = result_q;
    flags_d  = flags_q;
    fflags_d = fflags_clr_i ? '0 : fflags_q;
    load     = 1'b0;
`ifdef FP_CMP_CTRL_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid_i) load = 1'b1;
      end
      ISSUE: begin
        if (cmp_done_i) begin
          case (op_q)
            OP_FEQ:  result_d = cmp_eq_i;
            OP_FLT:  result_d = cmp_lt_i;
            default: result_d = cmp_le_i;
          endcase
          flags_d  = cmp_flags_i;
          fflags_d = fflags_d | cmp_flags_i;
          state_d  = RESP;
        end
`ifdef FP_CMP_CTRL_TIMEOUT_EN
        // Done in the timeout cycle still wins as a normal capture.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          result_d    = 1'b0;
          flags_d     = '0;
          flags_d.nv  = 1'b1;
          fflags_d.nv = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        // Back-to-back: a new request is taken in the handshake cycle.
        if (rsp_ready_i) begin
          if (req_valid_i) load = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      a_d      = req_a_i;
      b_d      = req_b_i;
      op_d     = req_op_i;
      tag_d    = req_tag_i;
      result_d = 1'b0;
      flags_d  = '0;
      // Reserved op answers directly without touching the comparator.
      state_d  = (req_op_i == OP_RSV) ? RESP : ISSUE;
`ifdef FP_CMP_CTRL_TIMEOUT_EN
      cnt_d    = '0;
`endif
    end
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      tag_q    <= '0;
      result_q <= 1'b0;
      flags_q  <= '0;
      fflags_q <= '0;
`ifdef FP_CMP_CTRL_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      fflags_q <= fflags_d;
`ifdef FP_CMP_CTRL_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Ready is forced low while reset is held, since IDLE would otherwise show it.
  assign req_ready_o  = !rst_i && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready_i));
  assign cmp_a_o      = a_q;
  assign cmp_b_o      = b_q;
  assign cmp_start_o  = (state_q == ISSUE);
  assign cmp_eq_en_o  = (state_q == ISSUE) && (op_q == OP_FEQ);
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_result_o = result_q;
  assign rsp_flags_o  = flags_q;
  assign rsp_tag_o    = tag_q;
  assign fflags_o     = fflags_q;

endmodule

// File: tb/tb_fp_cmp_ctrl.sv
// Scoreboard bench for fp_cmp_ctrl: stimulus pushes expected responses and
// comparator issues into queues, a negedge monitor pops and compares.
module tb_fp_cmp_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0, req_ready_o;
  logic [1:0]  req_op_i = '0;
  logic [31:0] req_a_i = '0, req_b_i = '0;
  logic [3:0]  req_tag_i = '0;
  logic [31:0] cmp_a_o, cmp_b_o;
  logic        cmp_start_o, cmp_eq_en_o, cmp_done_i;
  logic        cur_lt = 1'b0, cur_le = 1'b0, cur_eq = 1'b0;
  logic [4:0]  cur_flags = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b1, rsp_result_o;
  logic [4:0]  rsp_flags_o, fflags_o;
  logic [3:0]  rsp_tag_o;
  logic        fflags_clr_i = 1'b0;
  bit          done_en = 1'b1;

  int checks = 0, failures = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational comparator stand-in: done in the first ISSUE cycle.
  assign cmp_done_i = cmp_start_o & done_en;

  fp_cmp_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tag_i(req_tag_i),
    .cmp_a_o(cmp_a_o), .cmp_b_o(cmp_b_o), .cmp_start_o(cmp_start_o), .cmp_eq_en_o(cmp_eq_en_o),
    .cmp_lt_i(cur_lt), .cmp_le_i(cur_le), .cmp_eq_i(cur_eq), .cmp_done_i(cmp_done_i),
    .cmp_flags_i(cur_flags),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_flags_o(rsp_flags_o), .rsp_tag_o(rsp_tag_o),
    .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i)
  );

  typedef struct { logic res; logic [4:0] flags; logic [3:0] tag; int acc; int lat; } rsp_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic eq_en; } iss_t;
  rsp_t rq[$];
  iss_t iq[$];
  bit   seen = 1'b0;
  int   icnt = 0;
`ifdef FP_CMP_CTRL_TIMEOUT_EN
  localparam int TO_LIM = 16;
`else
  localparam int TO_LIM = 1 << 30;
`endif

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: comparator drive while started, response fields while valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmp_start_o) begin
        if (iq.size() == 0) chk("issue_unexpected", 1, 0);
        else begin
          chk("cmp_a", cmp_a_o, iq[0].a);
          chk("cmp_b", cmp_b_o, iq[0].b);
          chk("cmp_eq_en", cmp_eq_en_o, iq[0].eq_en);
          icnt++;
          if (cmp_done_i || icnt == TO_LIM) begin
            void'(iq.pop_front());
            icnt = 0;
          end
        end
      end
      if (rsp_valid_o) begin
        if (rq.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          chk("rsp_result", rsp_result_o, rq[0].res);
          chk("rsp_flags", rsp_flags_o, rq[0].flags);
          chk("rsp_tag", rsp_tag_o, rq[0].tag);
          if (!seen) begin
            seen = 1'b1;
            if (rq[0].lat >= 0) chk("rsp_latency", cyc - rq[0].acc, rq[0].lat);
          end
          if (rsp_ready_i) begin
            void'(rq.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [3:0] tag,
                      logic lt, logic le, logic eq, logic [4:0] fl,
                      logic eres, logic [4:0] eflags, int lat);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!req_ready_o && w < 50);
    if (!req_ready_o) begin
      chk("req_ready_wait", 0, 1);
      return;
    end
    cur_lt = lt; cur_le = le; cur_eq = eq; cur_flags = fl;
    req_valid_i = 1'b1; req_op_i = op; req_a_i = a; req_b_i = b; req_tag_i = tag;
    rq.push_back('{eres, eflags, tag, cyc, lat});
    if (op != 2'd3) iq.push_back('{a, b, (op == 2'd0)});
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (rq.size() != 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("drain_outstanding", rq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Outputs while reset is held, then ready in IDLE.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_cmp_start", cmp_start_o, 0);
    chk("rst_fflags", fflags_o, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", req_ready_o, 1);

    // FLT 1.0 < 2.0
    send(2'd1, 32'h3F800000, 32'h40000000, 4'h3, 1, 1, 0, 5'h00, 1, 5'h00, 2);
    drain();
    // +0 vs -0: FEQ, FLE, FLT
    send(2'd0, 32'h00000000, 32'h80000000, 4'h1, 0, 1, 1, 5'h00, 1, 5'h00, 2);
    send(2'd2, 32'h00000000, 32'h80000000, 4'h2, 0, 1, 1, 5'h00, 1, 5'h00, 2);
    send(2'd1, 32'h00000000, 32'h80000000, 4'h4, 0, 1, 1, 5'h00, 0, 5'h00, 2);
    drain();
    chk("fflags_clean", fflags_o, 5'h00);
    // qNaN: quiet FEQ, signalling FLT
    send(2'd0, 32'h7FC00000, 32'h3F800000, 4'h8, 0, 0, 0, 5'h00, 0, 5'h00, 2);
    send(2'd1, 32'h7FC00000, 32'h3F800000, 4'h9, 0, 0, 0, 5'h10, 0, 5'h10, 2);
    drain();
    @(negedge clk);
    chk("fflags_nv_sticky", fflags_o, 5'h10);
    fflags_clr_i = 1'b1;
    @(posedge clk);
    #1 fflags_clr_i = 1'b0;
    @(negedge clk);
    chk("fflags_cleared", fflags_o, 5'h00);

    // sNaN FEQ with a 3-cycle response stall, then back-to-back request
    send(2'd0, 32'h7F800001, 32'h3F800000, 4'h5, 0, 0, 0, 5'h10, 0, 5'h10, 2);
    rsp_ready_i = 1'b0;
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("stall_req_ready", req_ready_o, 0);
    end
    @(posedge clk);
    #1 rsp_ready_i = 1'b1;
    send(2'd2, 32'h3F800000, 32'h40000000, 4'h6, 1, 1, 0, 5'h00, 1, 5'h00, 2);
    drain();

    // Reserved op: no comparator start, immediate zero response
    send(2'd3, 32'h12345678, 32'h9ABCDEF0, 4'h7, 1, 1, 1, 5'h1F, 0, 5'h00, 1);
    drain();

    // Comparator never returns done
    done_en = 1'b0;
`ifdef FP_CMP_CTRL_TIMEOUT_EN
    send(2'd1, 32'h3F800000, 32'h40000000, 4'hC, 1, 1, 0, 5'h00, 0, 5'h10, 17);
    drain();
    chk("timeout_fflags", fflags_o, 5'h10);
    done_en = 1'b1;
`else
    send(2'd1, 32'h3F800000, 32'h40000000, 4'hC, 1, 1, 0, 5'h00, 1, 5'h00, -1);
    repeat (20) begin
      @(negedge clk);
      chk("stuck_start", cmp_start_o, 1);
      chk("stuck_no_rsp", rsp_valid_o, 0);
    end
    done_en = 1'b1;
    drain();
`endif

    // Reset while in ISSUE: start drops at once, op discarded
    done_en = 1'b0;
    send(2'd1, 32'h3F800000, 32'h40000000, 4'hA, 1, 1, 0, 5'h00, 1, 5'h00, 2);
    @(negedge clk);
    chk("pre_rst_start", cmp_start_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_start", cmp_start_o, 0);
    chk("midrst_rsp_valid", rsp_valid_o, 0);
    chk("midrst_req_ready", req_ready_o, 0);
    chk("midrst_fflags", fflags_o, 0);
    rq.delete();
    iq.delete();
    seen = 1'b0;
    icnt = 0;
    done_en = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    // Clean operation after reset; any stale response would be unexpected.
    send(2'd0, 32'h00000000, 32'h80000000, 4'hB, 0, 1, 1, 5'h00, 1, 5'h00, 2);
    drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
